alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Upstream/downstream companion to the 16-bit registered ALU/shifter stage.
- Holds an 8x16 register file and decodes one instruction at a time from a valid/ready host port.
- Drives registered ALU_control/Ainput/Binput to the ALU, then writes the ALU's registered Shift_output back into the destination register.
- Also supports a load-immediate instruction so the host can initialise registers.

Parameters:
- DATA_W, 16, datapath width; must equal the ALU width; the instruction format is fixed for 16.
- ZERO_REG, 1, when 1 register r0 always reads 0 and writes to it are discarded.
- REG_RESET, 16'h0000, value loaded into every register on reset.

Ports:
- Clock  in  1  rising-edge clock, shared with the ALU.
- Reset_n  in  1  asynchronous active-low reset.
- Instr_valid  in  1  host instruction valid.
- Instr  in  16  host instruction word.
- Instr_ready  out  1  sequencer can accept an instruction.
- Done  out  1  one-cycle pulse: the instruction's register write is being committed this cycle.
- ALU_control  out  3  to ALU; [2:1] operation, [0] shift-left-by-1.
- Ainput  out  16  to ALU operand A.
- Binput  out  16  to ALU operand B.
- Shift_output  in  16  from ALU; registered result, valid one clock after operands are applied.
- Rd_addr  in  3  host debug read address.
- Rd_data  out  16  combinational read of register Rd_addr (r0 reads 0 when ZERO_REG=1).

Behaviour:
- Clock is one clock; Reset_n is asynchronous and active-low.
- Reset (async assert, sync release):
  - state=IDLE; all registers = REG_RESET.
  - ALU_control=0, Ainput=0, Binput=0, Done=0, Instr_ready=1 after release.
  - A reset mid-instruction abandons it; no write occurs.
- Instruction format, ALU op (Instr[15]=0):
  - [14:12] ALU_control, [11:9] dst, [8:6] srcA, [5:3] srcB, [2:0] ignored.
- Instruction format, LOADI (Instr[15]=1):
  - [14:12] dst, [11:0] immediate, zero-extended to 16.
- Handshake:
  - Accept on a rising edge with Instr_valid && Instr_ready.
  - Instr_ready = (state==IDLE).
  - Instr must be held by the host until accepted; Instr_valid while busy is ignored.
- States: IDLE, EXEC, WB, LOAD.
  - IDLE: accept ALU op -> EXEC, same edge registers ALU_control, Ainput=reg[srcA], Binput=reg[srcB], latches dst. Accept LOADI -> LOAD, latches dst and immediate. No accept -> stay.
  - EXEC: one cycle; ALU computes; on the exiting edge the ALU captures Shift_output. -> WB.
  - WB: Done=1; on the exiting edge reg[dst] <= Shift_output. -> IDLE.
  - LOAD: Done=1; on the exiting edge reg[dst] <= immediate. -> IDLE.
- Latency: ALU op occupies 3 cycles (IDLE-accept, EXEC, WB); LOADI occupies 2. Back-to-back accept is possible on the cycle after WB/LOAD.
- ALU_control/Ainput/Binput hold their values until the next ALU-op accept; LOADI does not change them.
- Operand capture happens before writeback, so dst==srcA/srcB is legal and uses old values. srcA==srcB is legal.
- A write to r0 with ZERO_REG=1 is discarded; Done still pulses.
- Rd_data during WB/LOAD shows the old value; the new value is visible the cycle after.
- Arithmetic wraps modulo 2^16 in the ALU; the sequencer adds no width extension.

Optional Feature:
- Macro ALU_SEQ_ZFLAG_EN.
- When defined: adds output Zero_flag (1 bit, reset 0), registered on the WB/LOAD exiting edge as (written value == 0). It updates even when the write targets r0 and is discarded. It holds otherwise.
- When undefined: no Zero_flag port and no flag logic.

Test Plan:
- Reset: hold Reset_n=0 mid-EXEC -> state IDLE, Instr_ready=1, Done=0, Rd_data of every address = 0, ALU outputs 0.
- LOADI r1=0x005, LOADI r2=0x003 -> Done pulses once per load, 2 cycles apart; Rd_addr=1 gives 0x0005 the cycle after its Done.
- ADD r3=r1+r2 with shift (ALU_control=3'b001) -> Ainput=0x0005, Binput=0x0003 during EXEC; Done in the cycle 2 after accept; r3=0x0010.
- SUB r4=r2-r1 (ALU_control=3'b010) -> r4=0xFFFE (wrap). AND/OR r5 with 0x0F0/0x0FF -> 0x00F0 / 0x00FF.
- In-place OR r1=r1|r2 -> r1=0x0007; then write to r0 -> Rd_data(0)=0, Done still pulses; with ALU_SEQ_ZFLAG_EN, SUB r6=r1-r1 -> Zero_flag=1.
- Instr_valid held high continuously with alternating ops -> accepts only in IDLE, one accept per 3 (ALU op) or 2 (LOADI) cycles, none dropped or duplicated.

Source files
------------

// File: rtl/alu_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer_if
//   Host instruction port of the ALU operand sequencer.
//   Instr_valid / Instr / Instr_ready form a valid/ready handshake. Done is a
//   one-cycle pulse returned to the host when the instruction's register write
//   is committed.
//   Modports:
//     master - the host (drives Instr_valid, Instr; observes Instr_ready, Done)
//     slave  - the sequencer (the reverse)
// ---------------------------------------------------------------------------
interface alu_operand_sequencer_if;
    logic        Instr_valid;
    logic [15:0] Instr;
    logic        Instr_ready;
    logic        Done;

    modport master (
        output Instr_valid,
        output Instr,
        input  Instr_ready,
        input  Done
    );

    modport slave (
        input  Instr_valid,
        input  Instr,
        output Instr_ready,
        output Done
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
//   Front/back end for a 16-bit registered ALU/shifter. Holds an 8 x DATA_W
//   register file, accepts one instruction at a time from the host port,
//   presents registered ALU_control/Ainput/Binput to the ALU and writes the
//   ALU's registered Shift_output back into the destination register.
//   A load-immediate instruction initialises registers directly.
//
//   Instruction word:
//     Instr[15]=0 (ALU op): [14:12] ALU_control, [11:9] dst, [8:6] srcA,
//                           [5:3] srcB, [2:0] don't care
//     Instr[15]=1 (LOADI) : [14:12] dst, [11:0] immediate (zero-extended)
//
//   Ports:
//     Clock         rising-edge clock shared with the ALU
//     Reset_n       asynchronous active-low reset
//     host          instruction handshake (alu_operand_sequencer_if.slave)
//     ALU_control   to ALU: [2:1] operation, [0] shift left by one
//     Ainput/Binput to ALU operands
//     Shift_output  from ALU, valid one clock after operands are applied
//     Rd_addr       debug read address
//     Rd_data       combinational read of register Rd_addr
//     Zero_flag     (only with ALU_SEQ_ZFLAG_EN) last written value was zero
//
//   Optional feature macro: ALU_SEQ_ZFLAG_EN adds the Zero_flag output.
// ---------------------------------------------------------------------------
module alu_operand_sequencer #(
    parameter int                DATA_W    = 16,
    parameter bit                ZERO_REG  = 1'b1,
    parameter logic [DATA_W-1:0] REG_RESET = '0
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    alu_operand_sequencer_if.slave   host,
    output logic [2:0]               ALU_control,
    output logic [DATA_W-1:0]        Ainput,
    output logic [DATA_W-1:0]        Binput,
    input  logic [DATA_W-1:0]        Shift_output,
    input  logic [2:0]               Rd_addr,
    output logic [DATA_W-1:0]        Rd_data
`ifdef ALU_SEQ_ZFLAG_EN
    ,
    output logic                     Zero_flag
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        LOAD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        alu_ctrl_q, alu_ctrl_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [2:0]        dst_q, dst_d;
    logic [11:0]       imm_q, imm_d;

    // Committing a write this cycle (WB or LOAD) and the value being written.
    logic              commit;
    logic [DATA_W-1:0] wr_val;

    // Architectural view of each register: r0 reads as zero when ZERO_REG
    // is set, regardless of what its storage holds.
    logic [DATA_W-1:0] reg_view [8];

    assign commit = (state_q == WB) || (state_q == LOAD);
    assign wr_val = (state_q == LOAD) ? DATA_W'(imm_q) : Shift_output;

    // ------------------------------------------------------------------
    // Register file: one word per generate slot so each word has exactly
    // one driver. Writes to r0 are dropped when ZERO_REG is set.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 8; gi++) begin : g_reg
        logic [DATA_W-1:0] word_q, word_d;

        always_comb begin
            word_d = word_q;
            if (commit && (dst_q == 3'(gi)) && !(ZERO_REG && (gi == 0))) begin
                word_d = wr_val;
            end
        end

        always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
                word_q <= REG_RESET;
            end else begin
                word_q <= word_d;
            end
        end

        assign reg_view[gi] = (ZERO_REG && (gi == 0)) ? '0 : word_q;
    end

    // ------------------------------------------------------------------
    // Control FSM, next-state and operand capture. Operands are sampled
    // from the register file on the accept edge, before any writeback of
    // the same instruction, so dst may alias a source.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        alu_ctrl_d = alu_ctrl_q;
        a_d        = a_q;
        b_d        = b_q;
        dst_d      = dst_q;
        imm_d      = imm_q;

        case (state_q)
            IDLE: begin
                if (host.Instr_valid) begin
                    if (host.Instr[15]) begin
                        state_d = LOAD;
                        dst_d   = host.Instr[14:12];
                        imm_d   = host.Instr[11:0];
                    end else begin
                        state_d    = EXEC;
                        alu_ctrl_d = host.Instr[14:12];
                        dst_d      = host.Instr[11:9];
                        a_d        = reg_view[host.Instr[8:6]];
                        b_d        = reg_view[host.Instr[5:3]];
                    end
                end
            end
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            alu_ctrl_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            dst_q      <= '0;
            imm_q      <= '0;
        end else begin
            state_q    <= state_d;
            alu_ctrl_q <= alu_ctrl_d;
            a_q        <= a_d;
            b_q        <= b_d;
            dst_q      <= dst_d;
            imm_q      <= imm_d;
        end
    end

    assign host.Instr_ready = (state_q == IDLE);
    assign host.Done        = commit;
    assign ALU_control      = alu_ctrl_q;
    assign Ainput           = a_q;
    assign Binput           = b_q;
    assign Rd_data          = reg_view[Rd_addr];

`ifdef ALU_SEQ_ZFLAG_EN
    // Reflects the value written, even when the write to r0 is dropped.
    logic zflag_q, zflag_d;

    always_comb begin
        zflag_d = zflag_q;
        if (commit) begin
            zflag_d = (wr_val == '0);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            zflag_q <= 1'b0;
        end else begin
            zflag_q <= zflag_d;
        end
    end

    assign Zero_flag = zflag_q;
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
`timescale 1ns/1ps
module tb_alu_operand_sequencer;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  alu_control;
    logic [15:0] ainput, binput;
    logic [15:0] shift_output = 16'h0000;
    logic [2:0]  rd_addr = 3'd0;
    logic [15:0] rd_data;
`ifdef ALU_SEQ_ZFLAG_EN
    logic        zero_flag;
`endif

    always #5 clock = ~clock;

    alu_operand_sequencer_if host_if ();

    alu_operand_sequencer dut (
        .Clock        (clock),
        .Reset_n      (reset_n),
        .host         (host_if),
        .ALU_control  (alu_control),
        .Ainput       (ainput),
        .Binput       (binput),
        .Shift_output (shift_output),
        .Rd_addr      (rd_addr),
        .Rd_data      (rd_data)
`ifdef ALU_SEQ_ZFLAG_EN
        ,
        .Zero_flag    (zero_flag)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: architectural registers, last operands sent to
    // the ALU, and the zero flag.
    logic [15:0] mregs [8];
    logic [2:0]  last_ctrl;
    logic [15:0] last_a, last_b;
    logic        mzf;

    // Activity monitors.
    int accept_cnt = 0;
    int done_cnt   = 0;
    int cycle_cnt  = 0;

    // Behavioural ALU: ops ADD, SUB, AND, OR selected by [2:1], optional
    // shift-left-by-one in [0], wrap modulo 2^16.
    function automatic logic [15:0] alu_fn(input logic [2:0] c,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] r;
        case (c[2:1])
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a & b;
            default: r = a | b;
        endcase
        return c[0] ? (r << 1) : r;
    endfunction

    function automatic logic [15:0] mread(input logic [2:0] a);
        return (a == 3'd0) ? 16'h0000 : mregs[a];
    endfunction

    // Registered ALU companion plus handshake monitors.
    always @(posedge clock) begin
        shift_output <= alu_fn(alu_control, ainput, binput);
        cycle_cnt    <= cycle_cnt + 1;
        if (reset_n && host_if.Instr_valid && host_if.Instr_ready)
            accept_cnt <= accept_cnt + 1;
        if (reset_n && host_if.Done)
            done_cnt <= done_cnt + 1;
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
        last_ctrl = 3'd0;
        last_a    = 16'h0000;
        last_b    = 16'h0000;
        mzf       = 1'b0;
    endtask

    // Runs one instruction starting in an idle cycle (called just after a
    // falling edge) and returns just after the falling edge of the next
    // idle cycle. With hold=1 Instr_valid stays high with junk while busy.
    task automatic do_instr(input logic [15:0] ins, input bit hold);
        logic [2:0]  dst;
        logic [15:0] val, old_val;
        bit          is_load;
        is_load = ins[15];
        if (is_load) begin
            dst = ins[14:12];
            val = {4'h0, ins[11:0]};
        end else begin
            dst = ins[11:9];
            val = alu_fn(ins[14:12], mread(ins[8:6]), mread(ins[5:3]));
        end
        old_val = mread(dst);

        host_if.Instr       = ins;
        host_if.Instr_valid = 1'b1;
        checks++;
        if (host_if.Instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_accept ins=%h got %b exp 1", ins, host_if.Instr_ready);
        end
        @(negedge clock);
        host_if.Instr       = 16'($urandom);
        host_if.Instr_valid = hold;

        if (!is_load) begin
            last_ctrl = ins[14:12];
            last_a    = mread(ins[8:6]);
            last_b    = mread(ins[5:3]);
            checks++;
            if ({alu_control, ainput, binput} !== {last_ctrl, last_a, last_b}) begin
                errors++;
                $display("FAIL exec_operands ins=%h got ctl=%h a=%h b=%h exp ctl=%h a=%h b=%h",
                         ins, alu_control, ainput, binput, last_ctrl, last_a, last_b);
            end
            checks++;
            if ({host_if.Done, host_if.Instr_ready} !== 2'b00) begin
                errors++;
                $display("FAIL exec_done_ready ins=%h got %b%b exp 00", ins,
                         host_if.Done, host_if.Instr_ready);
            end
            @(negedge clock);
            host_if.Instr = 16'($urandom);
        end

        // Commit cycle (WB or LOAD).
        rd_addr = dst;
        #1;
        checks++;
        if ({host_if.Done, host_if.Instr_ready} !== 2'b10) begin
            errors++;
            $display("FAIL commit_done_ready ins=%h got %b%b exp 10", ins,
                     host_if.Done, host_if.Instr_ready);
        end
        checks++;
        if (rd_data !== old_val) begin
            errors++;
            $display("FAIL commit_old_value ins=%h r%0d got %h exp %h", ins, dst, rd_data, old_val);
        end
        checks++;
        if ({alu_control, ainput, binput} !== {last_ctrl, last_a, last_b}) begin
            errors++;
            $display("FAIL alu_hold ins=%h got ctl=%h a=%h b=%h exp ctl=%h a=%h b=%h",
                     ins, alu_control, ainput, binput, last_ctrl, last_a, last_b);
        end

        @(negedge clock);
        if (!hold) host_if.Instr_valid = 1'b0;
        if (dst != 3'd0) mregs[dst] = val;
        mzf = (val == 16'h0000);
        #1;
        checks++;
        if (rd_data !== mread(dst)) begin
            errors++;
            $display("FAIL writeback ins=%h r%0d got %h exp %h", ins, dst, rd_data, mread(dst));
        end
        checks++;
        if ({host_if.Done, host_if.Instr_ready} !== 2'b01) begin
            errors++;
            $display("FAIL after_commit_done_ready ins=%h got %b%b exp 01", ins,
                     host_if.Done, host_if.Instr_ready);
        end
`ifdef ALU_SEQ_ZFLAG_EN
        checks++;
        if (zero_flag !== mzf) begin
            errors++;
            $display("FAIL zero_flag ins=%h got %b exp %b", ins, zero_flag, mzf);
        end
`endif
    endtask

    task automatic test_reset();
        host_if.Instr_valid = 1'b0;
        host_if.Instr       = 16'h0000;
        reset_n             = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if ({host_if.Instr_ready, host_if.Done} !== 2'b10) begin
            errors++;
            $display("FAIL reset_ready_done got %b%b exp 10", host_if.Instr_ready, host_if.Done);
        end
        checks++;
        if ({alu_control, ainput, binput} !== 35'd0) begin
            errors++;
            $display("FAIL reset_alu_outputs got ctl=%h a=%h b=%h exp 0", alu_control, ainput, binput);
        end
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            checks++;
            if (rd_data !== 16'h0000) begin
                errors++;
                $display("FAIL reset_reg r%0d got %h exp 0000", a, rd_data);
            end
        end
`ifdef ALU_SEQ_ZFLAG_EN
        checks++;
        if (zero_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_zero_flag got %b exp 0", zero_flag);
        end
`endif
        @(negedge clock);
    endtask

    task automatic test_directed();
        logic [15:0] prog [12];
        logic [2:0]  reg_sel [12];
        logic [15:0] exp_val [12];
        prog = '{16'h9005, 16'hA003, 16'h1650, 16'h2888, 16'hE0F0, 16'hF0FF,
                 16'h4BB8, 16'h6BB8, 16'h6250, 16'h0050, 16'h2C48, 16'h8ABC};
        reg_sel = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd5, 3'd5, 3'd1, 3'd0, 3'd6, 3'd0};
        exp_val = '{16'h0005, 16'h0003, 16'h0010, 16'hFFFE, 16'h00F0, 16'h00FF,
                    16'h00F0, 16'h00FF, 16'h0007, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 12; i++) begin
            do_instr(prog[i], 1'b0);
            rd_addr = reg_sel[i];
            #1;
            checks++;
            if (rd_data !== exp_val[i]) begin
                errors++;
                $display("FAIL directed_%0d ins=%h r%0d got %h exp %h", i, prog[i],
                         reg_sel[i], rd_data, exp_val[i]);
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        host_if.Instr       = 16'h1650;
        host_if.Instr_valid = 1'b1;
        @(negedge clock);
        host_if.Instr_valid = 1'b0;
        reset_n             = 1'b0;
        #1;
        checks++;
        if ({host_if.Instr_ready, host_if.Done} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_ready_done got %b%b exp 10", host_if.Instr_ready, host_if.Done);
        end
        checks++;
        if ({alu_control, ainput, binput} !== 35'd0) begin
            errors++;
            $display("FAIL midreset_alu_outputs got ctl=%h a=%h b=%h exp 0", alu_control, ainput, binput);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            checks++;
            if (rd_data !== 16'h0000) begin
                errors++;
                $display("FAIL midreset_reg r%0d got %h exp 0000", a, rd_data);
            end
        end
        checks++;
        if ({host_if.Instr_ready, host_if.Done} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_no_write_done got %b%b exp 10", host_if.Instr_ready, host_if.Done);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int acc0, done0, cyc0, exp_cycles;
        logic [15:0] ins;
        @(negedge clock);
        #1;
        acc0 = accept_cnt; done0 = done_cnt; cyc0 = cycle_cnt;
        exp_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            ins     = 16'($urandom);
            ins[15] = (i % 2 == 0);
            exp_cycles += ins[15] ? 2 : 3;
            do_instr(ins, 1'b1);
        end
        host_if.Instr_valid = 1'b0;
        checks++;
        if (accept_cnt - acc0 !== 16) begin
            errors++;
            $display("FAIL b2b_accepts got %0d exp 16", accept_cnt - acc0);
        end
        checks++;
        if (done_cnt - done0 !== 16) begin
            errors++;
            $display("FAIL b2b_dones got %0d exp 16", done_cnt - done0);
        end
        checks++;
        if (cycle_cnt - cyc0 !== exp_cycles) begin
            errors++;
            $display("FAIL b2b_cycles got %0d exp %0d", cycle_cnt - cyc0, exp_cycles);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_instr(16'($urandom), 1'($urandom_range(0, 1)));
        end
        host_if.Instr_valid = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            checks++;
            if (rd_data !== mread(3'(a))) begin
                errors++;
                $display("FAIL random_final r%0d got %h exp %h", a, rd_data, mread(3'(a)));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_exec();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
